fsk_tone_detector: RTL and testbench
====================================

# fsk_tone_detector

Receive-side FSK demodulator for the ultrasonic modem, the counterpart to the transmit tone generator. It synchronises the comparator square wave from the receive transducer and measures the time between consecutive edges. Each half-period is classified as the low tone (bit 0) or the high tone (bit 1), and a majority-run filter turns those classifications into a debounced bit stream with a carrier-present flag. Its output feeds the bit-timing and framing logic.

## Interface
- `CNT_W`, 8, width of the half-period counter; the counter saturates at 2^CNT_W-1.
- `THRESH`, 91, half-period in cycles; m ≤ THRESH gives bit 1 (high tone), m > THRESH gives bit 0. Defaults assume a 50 MHz clk: 271.5 kHz ≈ 92 cycles, 277 kHz ≈ 90 cycles.
- `MIN_HALF`, 70, smallest valid half-period in cycles.
- `MAX_HALF`, 110, largest valid half-period; also the no-edge timeout.
- `VOTE_N`, 8, consecutive agreeing valid half-periods needed to lock or to change bit.
- `ERR_MAX`, 2, consecutive invalid half-periods that drop lock.
- `clk`  in  1  system clock.
- `rst`  in  1  reset, synchronous, active-low.
- `sig_in`  in  1  comparator output; asynchronous to clk.
- `bit_out`  out  1  current demodulated bit.
- `carrier`  out  1  high while the block is in LOCK.
- `bit_stb`  out  1  one-cycle pulse when `bit_out` is loaded (on lock or on a bit change).
- `half_period`  out  CNT_W  last measured half-period m.

## Operation
- **Synchroniser:** three flops s1 → s2 → s3. An edge is detected when s2 ≠ s3, covering both rising and falling transitions.
- **Counter `cnt`:**
  - Loads 1 on an edge cycle.
  - Otherwise increments, saturating at 2^CNT_W-1.
  - Reset value is 2^CNT_W-1, so the first edge after reset always yields an invalid measurement.
- **Measurement:** on an edge, m = the value of `cnt` before the reload. `half_period` is loaded with m.
- **Classification of m:**
  - m < MIN_HALF or m > MAX_HALF: invalid.
  - Otherwise: sym = (m ≤ THRESH).
- **Run filter (`run_sym`, `run_cnt`; `run_cnt` saturates at VOTE_N):**
  - Valid m with sym == run_sym: run_cnt increments.
  - Valid m with sym ≠ run_sym: run_sym ← sym, run_cnt ← 1.
  - Invalid m: run_cnt ← 0.
- **FSM, state SEARCH:**
  - `carrier` = 0.
  - When run_cnt becomes VOTE_N: go to LOCK, bit_out ← run_sym, pulse bit_stb, err_cnt ← 0.
- **FSM, state LOCK:**
  - `carrier` = 1.
  - When run_cnt becomes VOTE_N and run_sym ≠ bit_out: bit_out ← run_sym, pulse bit_stb.
  - Valid m clears err_cnt.
  - Invalid m increments err_cnt. Reaching ERR_MAX goes to SEARCH.
  - Timeout: cnt > MAX_HALF with no edge goes to SEARCH immediately and sets run_cnt ← 0.
- **On leaving LOCK:** `bit_out` holds its last value; no `bit_stb` pulse.
- **Edge and timeout in the same cycle:** the edge wins; the measurement is processed and the timeout is ignored.
- **Reset values:** bit_out=0, carrier=0, bit_stb=0, half_period=0, run_cnt=0, run_sym=0, err_cnt=0, s1..s3=0, FSM=SEARCH.
- **Reset mid-operation:** everything returns to the reset values on the next clk edge with rst low. No `bit_stb` is issued.

## Timing
- Let edge 1 be the first clk edge that samples a new sig_in level into s1.
  - s2 updates at edge 2.
  - `half_period`, `run_*`, FSM, `carrier`, `bit_out` and `bit_stb` update at edge 3.
  - Latency from sig_in transition to decision is therefore 3 cycles.
- Measurement jitter is ±1 cycle from the synchroniser.
- `bit_stb` is high for exactly one cycle, in the same cycle as the new `bit_out`.
- On lock, `carrier` rises in the same cycle as `bit_stb`.
- Timeout drop: `carrier` falls on the cycle where `cnt` first equals MAX_HALF+1, i.e. 110 cycles after the reload of the last edge.
- Throughput: every edge is processed. Edges closer than 1 cycle apart are impossible after synchronisation.

## Test plan
- **Reset:** hold rst=0 for 3 cycles while toggling sig_in -> all outputs 0; FSM in SEARCH.
- **Lock on high tone:** sig_in toggles every 90 cycles -> the first measurement is invalid; `carrier` = 1, `bit_out` = 1 and a single `bit_stb` occur at the 8th valid edge (9th edge overall); `half_period` = 90.
- **Tone switch:** from lock, change to 93-cycle half-periods -> `bit_out` → 0 with one `bit_stb` after the 8th 93-cycle measurement; `carrier` stays 1 throughout.
- **Boundaries:**
  - m=91 classifies as 1; m=92 as 0.
  - m=70 is valid; m=69 and m=111 are invalid.
  - Check via `run_cnt`/lock behaviour with 8-measurement runs.
- **Glitch tolerance:** in LOCK, one 50-cycle half-period -> `carrier` stays 1 and `bit_out` is unchanged. Two consecutive 50-cycle half-periods -> `carrier` = 0 at the second one's decision cycle.
- **Loss and reset mid-lock:**
  - Stop toggling in LOCK -> `carrier` falls 110 cycles after the last edge's reload; `bit_out` holds.
  - Separately, assert rst for 1 cycle in LOCK -> next cycle all outputs 0; relock requires a fresh 1 + 8 edges.

Source files
------------

// File: rtl/fsk_tone_detector.sv
// rtl/fsk_tone_detector.sv - FSK receive demodulator: edge timing, tone classification, run-filter lock
//
// Synchronises the comparator square wave, measures the time between
// consecutive edges (either polarity), classifies each half-period as the
// high tone (bit 1) or the low tone (bit 0), and debounces the result with a
// majority-run filter feeding a SEARCH/LOCK state machine.
//
// Ports:
//   clk          in   system clock
//   rst          in   synchronous active-low reset
//   sig_in       in   comparator output, asynchronous to clk
//   bit_out      out  current demodulated bit (holds its value when lock drops)
//   carrier      out  high while in LOCK
//   bit_stb      out  one-cycle pulse when bit_out is loaded (lock or bit change)
//   half_period  out  last measured half-period in clk cycles

module fsk_tone_detector #(
  parameter int CNT_W    = 8,
  parameter int THRESH   = 91,
  parameter int MIN_HALF = 70,
  parameter int MAX_HALF = 110,
  parameter int VOTE_N   = 8,
  parameter int ERR_MAX  = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sig_in,
  output logic             bit_out,
  output logic             carrier,
  output logic             bit_stb,
  output logic [CNT_W-1:0] half_period
);

  localparam int RUN_W = $clog2(VOTE_N + 1);
  localparam int ERR_W = $clog2(ERR_MAX + 1);

  localparam logic [CNT_W-1:0] CNT_SAT = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] THR_M   = CNT_W'(THRESH);
  localparam logic [CNT_W-1:0] MIN_M   = CNT_W'(MIN_HALF);
  localparam logic [CNT_W-1:0] MAX_M   = CNT_W'(MAX_HALF);
  localparam logic [RUN_W-1:0] RUN_ONE = RUN_W'(1);
  localparam logic [RUN_W-1:0] VOTE_R  = RUN_W'(VOTE_N);
  localparam logic [ERR_W-1:0] ERR_ONE = ERR_W'(1);
  localparam logic [ERR_W-1:0] ERR_R   = ERR_W'(ERR_MAX);

  typedef enum logic {
    SEARCH = 1'b0,
    LOCK   = 1'b1
  } state_t;

  logic             s1_q, s2_q, s3_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] half_period_q, half_period_d;
  logic             run_sym_q, run_sym_d;
  logic [RUN_W-1:0] run_cnt_q, run_cnt_d;
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
  logic [ERR_W-1:0] err_next;
  logic             bit_out_q, bit_out_d;
  logic             bit_stb_q, bit_stb_d;
  state_t           state_q, state_d;

  logic             edge_det;
  logic [CNT_W-1:0] m;
  logic             valid;
  logic             sym;
  logic             run_done;

  // Measurement, classification and run filter.
  always_comb begin
    edge_det      = s2_q ^ s3_q;
    m             = cnt_q;
    valid         = (m >= MIN_M) && (m <= MAX_M);
    sym           = (m <= THR_M);

    cnt_d         = cnt_q;
    half_period_d = half_period_q;
    run_sym_d     = run_sym_q;
    run_cnt_d     = run_cnt_q;

    if (edge_det) begin
      cnt_d = CNT_ONE;
    end else if (cnt_q != CNT_SAT) begin
      cnt_d = cnt_q + CNT_ONE;
    end

    if (edge_det) begin
      half_period_d = m;
      if (valid) begin
        if (sym == run_sym_q) begin
          if (run_cnt_q != VOTE_R) begin
            run_cnt_d = run_cnt_q + RUN_ONE;
          end
        end else begin
          run_sym_d = sym;
          run_cnt_d = RUN_ONE;
        end
      end else begin
        run_cnt_d = '0;
      end
    end

    // "Becomes VOTE_N": the run just reached the vote count, as opposed to
    // an already-saturated run absorbing one more agreeing measurement.
    // The second term only matters when VOTE_N is 1 and the symbol flips.
    run_done = edge_det && valid && (run_cnt_d == VOTE_R) &&
               ((run_cnt_q != VOTE_R) || (sym != run_sym_q));
  end

  // Lock state machine.
  always_comb begin
    state_d   = state_q;
    bit_out_d = bit_out_q;
    bit_stb_d = 1'b0;
    err_cnt_d = err_cnt_q;
    err_next  = err_cnt_q + ERR_ONE;

    unique case (state_q)
      SEARCH: begin
        if (run_done) begin
          state_d   = LOCK;
          bit_out_d = run_sym_d;
          bit_stb_d = 1'b1;
          err_cnt_d = '0;
        end
      end

      LOCK: begin
        if (edge_det) begin
          // An edge always wins over the timeout in the same cycle.
          if (valid) begin
            err_cnt_d = '0;
            if (run_done && (run_sym_d != bit_out_q)) begin
              bit_out_d = run_sym_d;
              bit_stb_d = 1'b1;
            end
          end else begin
            err_cnt_d = err_next;
            if (err_next == ERR_R) begin
              state_d = SEARCH;
            end
          end
        end else if (cnt_q >= MAX_M) begin
          // Decided one cycle early so that carrier is already low in the
          // cycle where cnt first reads MAX_HALF+1.
          state_d = SEARCH;
        end
      end

      default: state_d = SEARCH;
    endcase
  end

  // The timeout also clears the run filter; it only fires without an edge,
  // so it never conflicts with the run update above.
  logic [RUN_W-1:0] run_cnt_final;
  always_comb begin
    run_cnt_final = run_cnt_d;
    if ((state_q == LOCK) && !edge_det && (cnt_q >= MAX_M)) begin
      run_cnt_final = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      s1_q          <= 1'b0;
      s2_q          <= 1'b0;
      s3_q          <= 1'b0;
      cnt_q         <= CNT_SAT;
      half_period_q <= '0;
      run_sym_q     <= 1'b0;
      run_cnt_q     <= '0;
      err_cnt_q     <= '0;
      bit_out_q     <= 1'b0;
      bit_stb_q     <= 1'b0;
      state_q       <= SEARCH;
    end else begin
      s1_q          <= sig_in;
      s2_q          <= s1_q;
      s3_q          <= s2_q;
      cnt_q         <= cnt_d;
      half_period_q <= half_period_d;
      run_sym_q     <= run_sym_d;
      run_cnt_q     <= run_cnt_final;
      err_cnt_q     <= err_cnt_d;
      bit_out_q     <= bit_out_d;
      bit_stb_q     <= bit_stb_d;
      state_q       <= state_d;
    end
  end

  assign bit_out     = bit_out_q;
  assign carrier     = (state_q == LOCK);
  assign bit_stb     = bit_stb_q;
  assign half_period = half_period_q;

endmodule

// File: tb/tb_fsk_tone_detector.sv
// tb/tb_fsk_tone_detector.sv - directed bench for fsk_tone_detector with a bit_stb scoreboard

module tb_fsk_tone_detector;

  logic       clk = 1'b0;
  logic       rst;
  logic       sig_in;
  logic       bit_out;
  logic       carrier;
  logic       bit_stb;
  logic [7:0] half_period;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int since    = 1000;
  logic model_bit = 1'b0;

  typedef struct {
    int         cyc;
    logic       b;
    logic [7:0] hp;
  } sb_t;

  sb_t sb[$];
  sb_t mon_e;

  fsk_tone_detector #(
    .CNT_W(8), .THRESH(91), .MIN_HALF(70), .MAX_HALF(110), .VOTE_N(8), .ERR_MAX(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .sig_in(sig_in),
    .bit_out(bit_out),
    .carrier(carrier),
    .bit_stb(bit_stb),
    .half_period(half_period)
  );

  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Scoreboard side: every bit_stb must match the oldest pending expectation.
  always @(negedge clk) begin
    if (sb.size() > 0 && sb[0].cyc < cyc) begin
      check("stb_missing_at_cycle", 32'(cyc), 32'(sb[0].cyc));
      void'(sb.pop_front());
    end
    if (bit_stb === 1'b1) begin
      if (sb.size() == 0) begin
        check("stb_unexpected", 1, 0);
      end else begin
        mon_e = sb.pop_front();
        check("stb_cycle", 32'(cyc), 32'(mon_e.cyc));
        check("stb_bit_out", 32'(bit_out), 32'(mon_e.b));
        check("stb_carrier", 32'(carrier), 1);
        check("stb_half_period", 32'(half_period), 32'(mon_e.hp));
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      since++;
    end
  endtask

  // Toggle sig_in wait_m cycles after the previous toggle, then check the
  // decision three cycles later.
  task automatic edge_at(input int wait_m, input int exp_hp, input bit exp_car,
                         input bit stb, input bit b, input string tag);
    sb_t e;
    while (since < wait_m) begin
      @(negedge clk);
      since++;
    end
    sig_in = ~sig_in;
    since  = 0;
    if (stb) begin
      e.cyc = cyc + 3;
      e.b   = b;
      e.hp  = exp_hp[7:0];
      sb.push_back(e);
    end
    idle(3);
    if (stb) model_bit = b;
    check({tag, "_carrier"}, 32'(carrier), 32'(exp_car));
    check({tag, "_half_period"}, 32'(half_period), 32'(exp_hp));
    check({tag, "_bit_out"}, 32'(bit_out), 32'(model_bit));
  endtask

  task automatic run(input int count, input int m, input bit car_pre, input bit car_last,
                     input bit stb_last, input bit b, input string tag);
    for (int i = 1; i <= count; i++) begin
      edge_at(m, m, (i == count) ? car_last : car_pre, (i == count) && stb_last, b,
              $sformatf("%s_%0d", tag, i));
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_bit_out"}, 32'(bit_out), 0);
    check({tag, "_carrier"}, 32'(carrier), 0);
    check({tag, "_bit_stb"}, 32'(bit_stb), 0);
    check({tag, "_half_period"}, 32'(half_period), 0);
  endtask

  initial begin
    #1_200_000;
    $display("FAIL watchdog cycles=%0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst    = 1'b0;
    sig_in = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      sig_in = ~sig_in;
    end
    @(negedge clk);
    check_all_zero("reset");
    rst   = 1'b1;
    since = 1000;
    idle(20);

    // Lock on high tone: first edge invalid (saturated counter), lock on the 9th.
    edge_at(0, 255, 1'b0, 1'b0, 1'b0, "lock_first");
    run(8, 90, 1'b0, 1'b1, 1'b1, 1'b1, "lock_hi");

    // Tone switch to 93 cycles, then threshold and minimum boundaries.
    run(8, 93, 1'b1, 1'b1, 1'b1, 1'b0, "switch_lo");
    run(8, 91, 1'b1, 1'b1, 1'b1, 1'b1, "thr91");
    run(8, 92, 1'b1, 1'b1, 1'b1, 1'b0, "thr92");
    run(8, 70, 1'b1, 1'b1, 1'b1, 1'b1, "min70");

    // Glitches: a single one is tolerated, two in a row drop lock.
    edge_at(50, 50, 1'b1, 1'b0, 1'b0, "glitch1");
    edge_at(90, 90, 1'b1, 1'b0, 1'b0, "glitch_clear");
    edge_at(50, 50, 1'b1, 1'b0, 1'b0, "glitch2a");
    edge_at(50, 50, 1'b0, 1'b0, 1'b0, "glitch2b");

    // m=69 is invalid: it resets the run so 7+7 valid edges do not lock.
    run(7, 90, 1'b0, 1'b0, 1'b0, 1'b0, "pre69");
    edge_at(69, 69, 1'b0, 1'b0, 1'b0, "inv69");
    run(7, 90, 1'b0, 1'b0, 1'b0, 1'b0, "post69");
    edge_at(90, 90, 1'b1, 1'b1, 1'b1, "lock69");

    // Loss of signal: carrier falls 110 cycles after the last reload.
    idle(109);
    check("timeout_pre_carrier", 32'(carrier), 1);
    idle(1);
    check("timeout_carrier", 32'(carrier), 0);
    check("timeout_bit_out", 32'(bit_out), 1);
    idle(200);

    // m=111 is invalid.
    edge_at(0, 255, 1'b0, 1'b0, 1'b0, "post_timeout");
    run(7, 90, 1'b0, 1'b0, 1'b0, 1'b0, "pre111");
    edge_at(111, 111, 1'b0, 1'b0, 1'b0, "inv111");
    run(7, 90, 1'b0, 1'b0, 1'b0, 1'b0, "post111");
    edge_at(90, 90, 1'b1, 1'b1, 1'b1, "lock111");

    // Reset mid-lock, then a fresh 1 + 8 edges to relock.
    idle(20);
    rst    = 1'b0;
    sig_in = 1'b0;
    @(negedge clk);
    check_all_zero("midreset");
    rst       = 1'b1;
    model_bit = 1'b0;
    since     = 1000;
    idle(10);
    edge_at(0, 255, 1'b0, 1'b0, 1'b0, "relock_first");
    run(8, 90, 1'b0, 1'b1, 1'b1, 1'b1, "relock");

    idle(5);
    check("scoreboard_pending", 32'(sb.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
